uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Receive-side counterpart of the UART transmitter: recovers 8-bit frames from the serial `rx` line, checks optional parity and the stop bit, and presents each byte with status flags for one cycle to the downstream receive FIFO. It sits between the pad, which is driven by a peer's `tx`, and `fifo_sync`. It shares the transmitter's `baud_rate` and `parity_type` encodings so one register bank configures both directions.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz
- `OSR`, 16, oversampling ticks per bit
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `baud_rate`  in  2  00=2400, 01=4800, 10=9600, 11=19200 baud
- `parity_type`  in  2  00=none, 01=odd, 10=even, 11=none
- `rx`  in  1  asynchronous serial input, idle high
- `data_out`  out  8  received byte, LSB first on the line; holds its value until the next frame completes
- `data_valid`  out  1  one-cycle pulse when a frame completes
- `parity_err`  out  1  valid with `data_valid`: parity mismatch
- `frame_err`  out  1  valid with `data_valid`: stop bit sampled low
- `active`  out  1  high from start-bit detection until return to IDLE

## Operation
- `rx` passes through a 2-flop synchronizer with both flops reset to 1. All logic uses the synchronized `rxs`.
- Tick generator: divisor `DIV = CLK_HZ / (OSR * baud)`, integer truncation; 9600 baud at 50 MHz gives 325. It pulses `tick` for 1 cycle every DIV clocks. The counter is cleared when a start edge is detected, so ticks phase-align to the frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a falling `rxs` moves to START, clears the tick counter and the bit-tick counter, and latches `baud_rate` and `parity_type` for the whole frame. Config changes mid-frame are ignored.
  - START: at bit-tick 7 (mid-bit), if `rxs`=1 it is a false start and the FSM returns to IDLE with no output. If `rxs`=0, the FSM goes to DATA at bit-tick 15.
  - DATA: `rxs` is sampled at bit-tick 7 of each bit and shifted in LSB first. After 8 bits the FSM goes to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: samples the parity bit. The error is set when (odd: XOR of 8 data bits plus parity bit = 0) or (even: XOR = 1).
  - STOP: samples at bit-tick 7 and does not wait for the end of the stop bit. If `rxs`=1 it pulses `data_valid` and returns to IDLE. If `rxs`=0 it pulses `data_valid` with `frame_err`=1, then goes to BREAK.
  - BREAK: waits for `rxs`=1, then goes to IDLE. This prevents a held-low line from being read as a new start.
- `parity_err` and `frame_err` are only meaningful while `data_valid`=1, and are driven 0 otherwise. With parity disabled, `parity_err`=0.
- There is no backpressure. The consumer must accept the byte on the `data_valid` cycle.

## Timing
- Reset values: `data_out`=8'h00, `data_valid`=0, `parity_err`=0, `frame_err`=0, `active`=0, FSM=IDLE, synchronizer=1.
- Reset mid-frame returns everything to reset values immediately. A partial frame is discarded and no `data_valid` is produced.
- `active` rises 1 cycle after the synchronized falling edge.
- `data_valid` rises on the cycle after the stop-bit mid sample, which is about 9.5 bit periods (no parity) or 10.5 bit periods (parity) after the start edge, plus 2 synchronizer cycles.
- `active` falls in the same cycle `data_valid` pulses. If BREAK was entered, it falls on exit from BREAK.
- Back-to-back frames: the next start edge is accepted in the first IDLE cycle, because the stop sample occurs mid-stop-bit.

## Structure
- Package `uart_pkg` holds:
  - the baud and parity encoding localparams, shared with the TX path;
  - the FSM state enum;
  - a function `baud_div(CLK_HZ, OSR, code)`.
- Sub-module `rx_sample_tick`: a divisor counter with a synchronous clear input and a 1-cycle `tick` output.
- The FSM, shift register and parity check live in `uart_rx_core`.

## Test plan
- Baud 10 (9600), parity none, send 8'hA5 with stop=1 -> one `data_valid` pulse, `data_out`=8'hA5, both error flags 0, arriving ~9.5×5200 clocks after the start edge.
- Baud 10, even parity, send 8'h07 with parity bit 1 -> `data_out`=8'h07, `parity_err`=0. Resend with parity bit 0 -> `parity_err`=1.
- Odd parity, 8'h00 with stop bit 0 held low for 3 bit periods -> `data_valid`=1, `frame_err`=1. No second frame until the line goes high; the next good 8'h3C is received clean.
- Glitch: `rx` low for 3 bit-ticks, then high -> no `data_valid`, `active` returns to 0.
- Two back-to-back frames 8'h55, 8'hAA at 19200 with no idle gap -> two pulses with correct bytes.
- Assert `rst_n`=0 during bit 4 of 8'hFF -> all outputs go to reset values and no `data_valid`. The next frame 8'h12 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, RX state type and baud divisor helper
package uart_pkg;

  localparam logic [1:0] BAUD_2400       = 2'b00;
  localparam logic [1:0] BAUD_4800       = 2'b01;
  localparam logic [1:0] BAUD_9600       = 2'b10;
  localparam logic [1:0] BAUD_19200      = 2'b11;

  localparam logic [1:0] PARITY_NONE     = 2'b00;
  localparam logic [1:0] PARITY_ODD      = 2'b01;
  localparam logic [1:0] PARITY_EVEN     = 2'b10;
  localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

  localparam int unsigned DIV_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Clocks per oversampling tick; only ever called with constant arguments.
  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz,
                                                input int unsigned osr,
                                                input logic [1:0] code);
    int unsigned baud;
    baud = 32'd2400 << code;
    return DIV_W'(clk_hz / (osr * baud));
  endfunction

endpackage

// File: rtl/rx_sample_tick.sv
// rtl/rx_sample_tick.sv - oversampling tick divider with synchronous clear
module rx_sample_tick
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == div - DIV_W'(1));
  assign tick = wrap & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: synchronizer, frame FSM, parity and stop checks
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned OSR    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       active
);

  localparam logic [3:0] MID  = 4'(OSR / 2 - 1);
  localparam logic [3:0] LAST = 4'(OSR - 1);

  logic             rx_meta, rxs, rxs_prev;
  rx_state_t        state, state_n;
  logic [3:0]       btick, btick_n;
  logic [3:0]       nbits, nbits_n;
  logic [7:0]       shreg, shreg_n;
  logic             par_bit, par_bit_n;
  logic [1:0]       cfg_baud, cfg_baud_n;
  logic [1:0]       cfg_par, cfg_par_n;
  logic             emit, frame_bad, par_en, par_bad;
  logic             tick, tick_clr;
  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  always_comb begin
    unique case (cfg_baud)
      BAUD_2400: div = baud_div(CLK_HZ, OSR, BAUD_2400);
      BAUD_4800: div = baud_div(CLK_HZ, OSR, BAUD_4800);
      BAUD_9600: div = baud_div(CLK_HZ, OSR, BAUD_9600);
      default:   div = baud_div(CLK_HZ, OSR, BAUD_19200);
    endcase
  end

  rx_sample_tick u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .div  (div),
    .tick (tick)
  );

  assign par_en  = (cfg_par == PARITY_ODD) || (cfg_par == PARITY_EVEN);
  assign par_bad = par_en && (((^shreg) ^ par_bit) == (cfg_par == PARITY_EVEN));
  assign active  = (state != ST_IDLE);

  always_comb begin
    state_n    = state;
    btick_n    = btick;
    nbits_n    = nbits;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    cfg_baud_n = cfg_baud;
    cfg_par_n  = cfg_par;
    emit       = 1'b0;
    frame_bad  = 1'b0;
    tick_clr   = 1'b0;
    if (tick) btick_n = btick + 4'd1;
    unique case (state)
      ST_IDLE: begin
        // Holding the divider in clear keeps ticks phase-aligned to the start edge.
        tick_clr = 1'b1;
        btick_n  = 4'd0;
        if (rxs_prev && !rxs) begin
          state_n    = ST_START;
          nbits_n    = 4'd0;
          cfg_baud_n = baud_rate;
          cfg_par_n  = parity_type;
        end
      end
      ST_START: if (tick) begin
        if (btick == MID && rxs) state_n = ST_IDLE;
        else if (btick == LAST)  state_n = ST_DATA;
      end
      ST_DATA: if (tick) begin
        if (btick == MID) begin
          shreg_n = {rxs, shreg[7:1]};
          nbits_n = nbits + 4'd1;
        end else if (btick == LAST && nbits == 4'd8) begin
          state_n = par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (tick) begin
        if (btick == MID)       par_bit_n = rxs;
        else if (btick == LAST) state_n   = ST_STOP;
      end
      ST_STOP: if (tick && btick == MID) begin
        emit      = 1'b1;
        frame_bad = ~rxs;
        state_n   = rxs ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: if (rxs) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      btick      <= 4'd0;
      nbits      <= 4'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      cfg_baud   <= BAUD_2400;
      cfg_par    <= PARITY_NONE;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      btick      <= btick_n;
      nbits      <= nbits_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      cfg_baud   <= cfg_baud_n;
      cfg_par    <= cfg_par_n;
      data_valid <= emit;
      parity_err <= emit & par_bad;
      frame_err  <= emit & frame_bad;
      if (emit) data_out <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core against a frame-level model
module tb_uart_rx_core;

  localparam int unsigned CLK_HZ = 1_228_800;
  localparam int unsigned OSR    = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] baud_rate = 2'b10;
  logic [1:0] parity_type = 2'b00;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, active;

  int          n_checks = 0;
  int          n_fail = 0;
  int          stray = 0;
  logic [31:0] cyc = 0;
  int          baud_tbl [4] = '{2400, 4800, 9600, 19200};

  typedef struct packed {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    logic        act;
    logic [31:0] cyc;
  } rec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  rec_t got_q[$];
  rec_t mon_rec;

  uart_rx_core #(.CLK_HZ(CLK_HZ), .OSR(OSR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_rate  (baud_rate),
    .parity_type(parity_type),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .active     (active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      mon_rec.data = data_out;
      mon_rec.perr = parity_err;
      mon_rec.ferr = frame_err;
      mon_rec.act  = active;
      mon_rec.cyc  = cyc;
      got_q.push_back(mon_rec);
    end else if (parity_err || frame_err) begin
      stray++;
    end
  end

  function automatic int tick_clocks(input logic [1:0] code);
    return int'(CLK_HZ) / (int'(OSR) * baud_tbl[code]);
  endfunction

  function automatic int bit_clocks(input logic [1:0] code);
    return int'(OSR) * tick_clocks(code);
  endfunction

  // Error flags follow from what was actually put on the line.
  function automatic exp_t model(input logic [7:0] d, input logic [1:0] par,
                                 input logic pbit, input logic stop_val);
    exp_t e;
    logic ones_odd;
    ones_odd = (^d) ^ pbit;
    e.data = d;
    e.perr = (par == 2'b01 && !ones_odd) || (par == 2'b10 && ones_odd);
    e.ferr = !stop_val;
    return e;
  endfunction

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] baud, input logic [1:0] par,
                            input logic flip, input logic stop_val, input int stop_bits,
                            input int idle_bits, input logic scramble,
                            output logic pbit, output logic [31:0] t0);
    int bitp;
    bitp        = bit_clocks(baud);
    baud_rate   = baud;
    parity_type = par;
    pbit        = ((par == 2'b01) ? ~(^d) : (^d)) ^ flip;
    t0          = cyc;
    rx          = 1'b0;
    if (scramble) begin
      hold(bitp / 2);
      baud_rate   = 2'($urandom);
      parity_type = 2'($urandom);
      hold(bitp - bitp / 2);
    end else begin
      hold(bitp);
    end
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(bitp);
    end
    if (par == 2'b01 || par == 2'b10) begin
      rx = pbit;
      hold(bitp);
    end
    rx = stop_val;
    hold(bitp * stop_bits);
    rx = 1'b1;
    hold(bitp * idle_bits);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    hold(3);
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", active); end
    rst_n = 1'b1;
    hold(4);
  endtask

  task automatic test_basic;
    logic pb; logic [31:0] t0; exp_t e; int bitp, lat, exp_lat, tol;
    got_q.delete();
    send_frame(8'hA5, 2'b10, 2'b00, 1'b0, 1'b1, 1, 1, 1'b0, pb, t0);
    e = model(8'hA5, 2'b00, pb, 1'b1);
    bitp    = bit_clocks(2'b10);
    exp_lat = (19 * bitp) / 2 + 2;
    tol     = bitp / int'(OSR) + 3;
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL basic_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      lat = int'(got_q[0].cyc - t0);
      n_checks++; if (got_q[0].data !== e.data) begin n_fail++; $display("FAIL basic_data got=%h exp=%h", got_q[0].data, e.data); end
      n_checks++; if ({got_q[0].perr, got_q[0].ferr} !== {e.perr, e.ferr}) begin n_fail++; $display("FAIL basic_flags got=%b%b exp=%b%b", got_q[0].perr, got_q[0].ferr, e.perr, e.ferr); end
      n_checks++; if (got_q[0].act !== 1'b0) begin n_fail++; $display("FAIL basic_active_at_valid got=%b exp=0", got_q[0].act); end
      n_checks++; if (lat < exp_lat - tol || lat > exp_lat + tol) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d+-%0d", lat, exp_lat, tol); end
    end
  endtask

  task automatic test_parity;
    logic pb; logic [31:0] t0; exp_t e;
    for (int k = 0; k < 2; k++) begin
      got_q.delete();
      send_frame(8'h07, 2'b10, 2'b10, k[0], 1'b1, 1, 1, 1'b0, pb, t0);
      e = model(8'h07, 2'b10, pb, 1'b1);
      n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL parity_count[%0d] got=%0d exp=1", k, got_q.size()); end
      if (got_q.size() >= 1) begin
        n_checks++; if (got_q[0].data !== e.data) begin n_fail++; $display("FAIL parity_data[%0d] got=%h exp=%h", k, got_q[0].data, e.data); end
        n_checks++; if (got_q[0].perr !== e.perr) begin n_fail++; $display("FAIL parity_err[%0d] got=%b exp=%b", k, got_q[0].perr, e.perr); end
      end
    end
  endtask

  task automatic test_break;
    logic pb; logic [31:0] t0; exp_t e;
    got_q.delete();
    send_frame(8'h00, 2'b10, 2'b01, 1'b0, 1'b0, 3, 0, 1'b0, pb, t0);
    e = model(8'h00, 2'b01, pb, 1'b0);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL break_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if ({got_q[0].data, got_q[0].perr, got_q[0].ferr} !== {e.data, e.perr, e.ferr}) begin n_fail++; $display("FAIL break_frame got=%h/%b/%b exp=%h/%b/%b", got_q[0].data, got_q[0].perr, got_q[0].ferr, e.data, e.perr, e.ferr); end
    end
    n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL break_active_held got=%b exp=1", active); end
    hold(2 * bit_clocks(2'b10));
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL break_active_released got=%b exp=0", active); end
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL break_no_second got=%0d exp=1", got_q.size()); end
    got_q.delete();
    send_frame(8'h3C, 2'b10, 2'b01, 1'b0, 1'b1, 1, 1, 1'b0, pb, t0);
    e = model(8'h3C, 2'b01, pb, 1'b1);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL break_next_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if ({got_q[0].data, got_q[0].perr, got_q[0].ferr} !== {e.data, e.perr, e.ferr}) begin n_fail++; $display("FAIL break_next_frame got=%h/%b/%b exp=%h/%b/%b", got_q[0].data, got_q[0].perr, got_q[0].ferr, e.data, e.perr, e.ferr); end
    end
  endtask

  task automatic test_glitch;
    got_q.delete();
    baud_rate   = 2'b10;
    parity_type = 2'b00;
    rx = 1'b0;
    hold(2);
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL glitch_active_early got=%b exp=0", active); end
    hold(1);
    n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL glitch_active_rise got=%b exp=1", active); end
    hold(3 * tick_clocks(2'b10) - 3);
    rx = 1'b1;
    hold(2 * bit_clocks(2'b10));
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL glitch_no_valid got=%0d exp=0", got_q.size()); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL glitch_active_fall got=%b exp=0", active); end
  endtask

  task automatic test_back_to_back;
    logic pb; logic [31:0] t0;
    got_q.delete();
    send_frame(8'h55, 2'b11, 2'b00, 1'b0, 1'b1, 1, 0, 1'b0, pb, t0);
    send_frame(8'hAA, 2'b11, 2'b00, 1'b0, 1'b1, 1, 1, 1'b0, pb, t0);
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_checks++; if (got_q[0].data !== 8'h55) begin n_fail++; $display("FAIL b2b_first got=%h exp=55", got_q[0].data); end
      n_checks++; if (got_q[1].data !== 8'hAA) begin n_fail++; $display("FAIL b2b_second got=%h exp=aa", got_q[1].data); end
      n_checks++; if ({got_q[0].perr, got_q[0].ferr, got_q[1].perr, got_q[1].ferr} !== 4'b0000) begin n_fail++; $display("FAIL b2b_flags got=%b%b%b%b exp=0000", got_q[0].perr, got_q[0].ferr, got_q[1].perr, got_q[1].ferr); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic pb; logic [31:0] t0; exp_t e; int bitp;
    bitp = bit_clocks(2'b10);
    got_q.delete();
    baud_rate   = 2'b10;
    parity_type = 2'b00;
    rx = 1'b0;
    hold(bitp);
    rx = 1'b1;
    hold(4 * bitp + bitp / 2);
    rst_n = 1'b0;
    hold(2);
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL midreset_data_out got=%h exp=00", data_out); end
    n_checks++; if ({data_valid, parity_err, frame_err, active} !== 4'b0000) begin n_fail++; $display("FAIL midreset_outputs got=%b exp=0000", {data_valid, parity_err, frame_err, active}); end
    rst_n = 1'b1;
    hold(7 * bitp);
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL midreset_no_valid got=%0d exp=0", got_q.size()); end
    send_frame(8'h12, 2'b10, 2'b00, 1'b0, 1'b1, 1, 1, 1'b0, pb, t0);
    e = model(8'h12, 2'b00, pb, 1'b1);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL midreset_next_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if ({got_q[0].data, got_q[0].perr, got_q[0].ferr} !== {e.data, e.perr, e.ferr}) begin n_fail++; $display("FAIL midreset_next_frame got=%h/%b/%b exp=%h/%b/%b", got_q[0].data, got_q[0].perr, got_q[0].ferr, e.data, e.perr, e.ferr); end
    end
  endtask

  task automatic test_random;
    logic pb; logic [31:0] t0; exp_t e;
    logic [7:0] d; logic [1:0] baud, par; logic flip;
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      baud = 2'($urandom_range(1, 3));
      par  = 2'($urandom_range(0, 3));
      flip = 1'($urandom_range(0, 1));
      got_q.delete();
      send_frame(d, baud, par, flip, 1'b1, 1, int'($urandom_range(0, 2)), 1'b1, pb, t0);
      e = model(d, par, pb, 1'b1);
      n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL random_count[%0d] got=%0d exp=1", i, got_q.size()); end
      if (got_q.size() >= 1) begin
        n_checks++; if ({got_q[0].data, got_q[0].perr, got_q[0].ferr} !== {e.data, e.perr, e.ferr}) begin n_fail++; $display("FAIL random_frame[%0d] baud=%0d par=%0d got=%h/%b/%b exp=%h/%b/%b", i, baud, par, got_q[0].data, got_q[0].perr, got_q[0].ferr, e.data, e.perr, e.ferr); end
      end
    end
  endtask

  task automatic test_flags_quiet;
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL flags_without_valid got=%0d exp=0", stray); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_flags_quiet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
